serial_comparator: RTL and testbench
====================================

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 SHALL have parameter DIGIT_W, default 4, bits compared per cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have port iClk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port iRst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port iValid  input  1  request valid; operands and mode presented.
REQ-005 SHALL have port oReady  output  1  block can accept a request.
REQ-006 SHALL have port iDataA  input  32  operand A.
REQ-007 SHALL have port iDataB  input  32  operand B.
REQ-008 SHALL have port iSigned  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-009 SHALL have port oValid  output  1  result valid.
REQ-010 SHALL have port iReady  input  1  consumer accepts result.
REQ-011 SHALL have port oData  output  3  relation code: bit2 = A<B, bit1 = A==B, bit0 = A>B.
REQ-012 SHALL have port oSet  output  32  set-less-than value: 32'b1 when oData[2]=1, else 32'b0.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; oReady=1 only in IDLE, oValid=1 only in DONE.
REQ-014 SHALL accept a request when iValid && oReady on a rising edge, latch both operands and go IDLE->RUN.
REQ-015 SHALL, when iSigned=1 at acceptance, invert bit 31 of both latched operands, then compare unsigned.
REQ-016 SHALL, each RUN cycle, compare one DIGIT_W-bit digit of A against B, starting at bits [31:32-DIGIT_W] and moving toward the LSB.
REQ-017 SHALL, on the first unequal digit, set oData to 3'b100 (A digit < B digit) or 3'b001 (A digit > B digit) and go RUN->DONE on that edge (early termination).
REQ-018 SHALL, when all 32/DIGIT_W digits are equal, set oData to 3'b010 and go RUN->DONE on the edge that processes the last digit.
REQ-019 SHALL have latency 1 to 32/DIGIT_W cycles from acceptance edge to oValid=1 (1 to 8 at DIGIT_W=4).
REQ-020 SHALL hold oData and oSet stable while oValid=1 and iReady=0.
REQ-021 SHALL go DONE->IDLE on the edge where iReady=1; oValid drops and oReady rises on the same edge.
REQ-022 SHALL NOT accept a new request in the cycle oValid falls; next acceptance is at the earliest one cycle after.
REQ-023 SHALL ignore iValid, iDataA, iDataB and iSigned changes while in RUN or DONE.
REQ-024 SHALL use a digit counter of width log2(32/DIGIT_W) that resets to 0 on every acceptance.
REQ-025 SHALL keep oData one-hot whenever oValid=1.

Reset
REQ-026 SHALL, while iRst=1 at a rising edge, enter IDLE with oReady=1, oValid=0, oData=3'b000, oSet=32'h0, counter=0.
REQ-027 SHALL abandon any RUN or DONE operation on reset, with no result emitted afterward.
REQ-028 SHALL give reset priority over a simultaneous iValid or iReady.

Verification
REQ-029 Unsigned: A=32'h0000_0001, B=32'hFFFF_FFFF, iSigned=0 -> oData=3'b100, oSet=32'h1, oValid 1 cycle after acceptance (MSB digit differs).
REQ-030 Signed: same operands, iSigned=1 -> oData=3'b001, oSet=32'h0.
REQ-031 Equal: A=B=32'h1234_5678, DIGIT_W=4 -> oData=3'b010 after exactly 8 RUN cycles.
REQ-032 LSB-only difference: A=32'h8000_0000, B=32'h8000_0001, iSigned=0 -> oData=3'b100 after 8 cycles, and the same operands with iSigned=1 -> 3'b100.
REQ-033 Backpressure: hold iReady=0 for 5 cycles in DONE -> oData and oSet stable, oReady=0, new iValid ignored; iReady=1 -> IDLE next edge.
REQ-034 Reset mid-RUN: assert iRst on the 3rd RUN cycle -> next edge IDLE, oValid=0, oData=3'b000; a fresh request then completes correctly.

Source files
------------

// File: rtl/serial_comparator.sv
// Digit-serial magnitude comparator: scans two 32-bit operands MSB-first,
// DIGIT_W bits per cycle, and stops at the first digit that differs.
module serial_comparator #(
    parameter int DIGIT_W = 4  // 1, 2, 4 or 8
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iValid,
    output logic        oReady,
    input  logic [31:0] iDataA,
    input  logic [31:0] iDataB,
    input  logic        iSigned,
    output logic        oValid,
    input  logic        iReady,
    output logic [2:0]  oData,
    output logic [31:0] oSet
);

    localparam int NUM_DIGITS = 32 / DIGIT_W;
    localparam int CNT_W      = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             stateReg;
    logic [31:0]        aReg;
    logic [31:0]        bReg;
    logic [CNT_W-1:0]   cntReg;

    logic [DIGIT_W-1:0] aDigits [NUM_DIGITS];
    logic [DIGIT_W-1:0] bDigits [NUM_DIGITS];
    logic [DIGIT_W-1:0] aDigit;
    logic [DIGIT_W-1:0] bDigit;
    logic               lastDigit;

    // Digit 0 is the most significant slice, so the counter walks toward the LSB.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : gDigit
            assign aDigits[gi] = aReg[32 - DIGIT_W * (gi + 1) +: DIGIT_W];
            assign bDigits[gi] = bReg[32 - DIGIT_W * (gi + 1) +: DIGIT_W];
        end
    endgenerate

    assign aDigit    = aDigits[cntReg];
    assign bDigit    = bDigits[cntReg];
    assign lastDigit = (cntReg == CNT_W'(NUM_DIGITS - 1));

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateReg <= IDLE;
            oReady   <= 1'b1;
            oValid   <= 1'b0;
            oData    <= 3'b000;
            oSet     <= 32'h0;
            cntReg   <= '0;
            aReg     <= 32'h0;
            bReg     <= 32'h0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (iValid) begin
                        // Flipping the sign bit maps two's-complement order onto unsigned order.
                        aReg     <= {iDataA[31] ^ iSigned, iDataA[30:0]};
                        bReg     <= {iDataB[31] ^ iSigned, iDataB[30:0]};
                        cntReg   <= '0;
                        oData    <= 3'b000;
                        oSet     <= 32'h0;
                        oReady   <= 1'b0;
                        stateReg <= RUN;
                    end
                end
                RUN: begin
                    if (aDigit != bDigit) begin
                        oData    <= (aDigit < bDigit) ? 3'b100 : 3'b001;
                        oSet     <= {31'b0, aDigit < bDigit};
                        oValid   <= 1'b1;
                        stateReg <= DONE;
                    end else if (lastDigit) begin
                        oData    <= 3'b010;
                        oSet     <= 32'h0;
                        oValid   <= 1'b1;
                        stateReg <= DONE;
                    end else begin
                        cntReg <= cntReg + 1'b1;
                    end
                end
                DONE: begin
                    if (iReady) begin
                        oValid   <= 1'b0;
                        oReady   <= 1'b1;
                        stateReg <= IDLE;
                    end
                end
                default: begin
                    oValid   <= 1'b0;
                    oReady   <= 1'b1;
                    stateReg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator: arithmetic reference model plus
// hand-computed expectations for each vector.
module tb_serial_comparator;

    localparam int DW = 4;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iValid;
    logic        oReady;
    logic [31:0] iDataA;
    logic [31:0] iDataB;
    logic        iSigned;
    logic        oValid;
    logic        iReady;
    logic [2:0]  oData;
    logic [31:0] oSet;

    int       nVec = 0;
    int       nMis = 0;
    logic [2:0] expData = 3'b000;
    bit       expArmed = 1'b0;

    serial_comparator #(.DIGIT_W(DW)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iValid (iValid),
        .oReady (oReady),
        .iDataA (iDataA),
        .iDataB (iDataB),
        .iSigned(iSigned),
        .oValid (oValid),
        .iReady (iReady),
        .oData  (oData),
        .oSet   (oSet)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Relation from plain integer comparison.
    function automatic logic [2:0] modelRel(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) begin
            if ($signed(a) < $signed(b)) return 3'b100;
            if ($signed(a) > $signed(b)) return 3'b001;
        end else begin
            if (a < b) return 3'b100;
            if (a > b) return 3'b001;
        end
        return 3'b010;
    endfunction

    // Cycles to result: position of the highest differing bit, grouped into digits.
    function automatic int modelLat(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        x = a ^ b;
        for (int i = 31; i >= 0; i--)
            if (x[i]) return (31 - i) / DW + 1;
        return 32 / DW;
    endfunction

    // Every cycle a result is presented it must match the model and be one-hot.
    always @(negedge iClk) begin
        if (!iRst && oValid) begin
            if (expArmed) begin
                check("mon_oData", {29'b0, oData}, {29'b0, expData});
                check("mon_oSet", oSet, {31'b0, expData[2]});
                check("mon_onehot", {31'b0, $onehot(oData)}, 32'd1);
            end else begin
                check("mon_unexpected_oValid", {31'b0, oValid}, 32'd0);
            end
        end
    end

    task automatic waitReady(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge iClk);
            if (oReady) ok = 1'b1;
        end
        check({name, "_ready"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic runReq(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [2:0] litData, input int litLat,
                          input int hold);
        int lat;
        bit got;
        expData  = modelRel(a, b, s);
        expArmed = 1'b1;
        waitReady(name);
        iValid  = 1'b1;
        iDataA  = a;
        iDataB  = b;
        iSigned = s;
        @(posedge iClk);
        #1;
        // Junk request kept valid while busy; it must be ignored.
        iDataA  = ~a;
        iDataB  = $urandom;
        iSigned = ~s;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge iClk);
            #1;
            lat++;
            if (oValid) got = 1'b1;
        end
        if (!got) begin
            check({name, "_timeout"}, {31'b0, got}, 32'd1);
            iValid = 1'b0;
            iRst   = 1'b1;
            @(posedge iClk);
            #1;
            iRst     = 1'b0;
            expArmed = 1'b0;
            return;
        end
        check({name, "_lat_lit"}, lat, litLat);
        check({name, "_lat_model"}, lat, modelLat(a, b));
        check({name, "_oData"}, {29'b0, oData}, {29'b0, litData});
        check({name, "_oSet"}, oSet, {31'b0, litData[2]});
        for (int i = 0; i < hold; i++) begin
            @(posedge iClk);
            #1;
            check({name, "_hold_oValid"}, {31'b0, oValid}, 32'd1);
            check({name, "_hold_oReady"}, {31'b0, oReady}, 32'd0);
            check({name, "_hold_oData"}, {29'b0, oData}, {29'b0, litData});
            check({name, "_hold_oSet"}, oSet, {31'b0, litData[2]});
        end
        iValid = 1'b0;
        iReady = 1'b1;
        @(posedge iClk);
        #1;
        check({name, "_release_oValid"}, {31'b0, oValid}, 32'd0);
        check({name, "_release_oReady"}, {31'b0, oReady}, 32'd1);
        iReady   = 1'b0;
        expArmed = 1'b0;
        $display("txn %s: A=%h B=%h signed=%0d -> oData=%b latency=%0d", name, a, b, s, litData, lat);
    endtask

    initial begin
        iRst    = 1'b1;
        iValid  = 1'b0;
        iReady  = 1'b0;
        iDataA  = 32'h0;
        iDataB  = 32'h0;
        iSigned = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        check("rst_oReady", {31'b0, oReady}, 32'd1);
        check("rst_oValid", {31'b0, oValid}, 32'd0);
        check("rst_oData", {29'b0, oData}, 32'd0);
        check("rst_oSet", oSet, 32'h0);
        iRst = 1'b0;

        runReq("uns_msb",     32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 3'b100, 1, 0);
        runReq("sgn_msb",     32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 3'b001, 1, 0);
        runReq("equal",       32'h1234_5678, 32'h1234_5678, 1'b0, 3'b010, 8, 0);
        runReq("uns_lsb",     32'h8000_0000, 32'h8000_0001, 1'b0, 3'b100, 8, 0);
        runReq("sgn_lsb",     32'h8000_0000, 32'h8000_0001, 1'b1, 3'b100, 8, 0);
        runReq("backpress",   32'h1234_5678, 32'h1234_5778, 1'b0, 3'b100, 6, 5);
        runReq("gt_lsb",      32'h0000_0005, 32'h0000_0003, 1'b0, 3'b001, 8, 0);
        runReq("sgn_neg_pos", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 3'b100, 1, 0);
        runReq("uns_neg_pos", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 3'b001, 1, 0);
        runReq("mid_gt",      32'h00A0_0000, 32'h0090_FFFF, 1'b0, 3'b001, 3, 2);

        // Reset during the third RUN cycle of an all-equal compare.
        waitReady("rst_mid");
        expArmed = 1'b0;
        iValid   = 1'b1;
        iDataA   = 32'h1234_5678;
        iDataB   = 32'h1234_5678;
        iSigned  = 1'b0;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        @(posedge iClk);
        @(posedge iClk);
        #1;
        iRst = 1'b1;
        @(posedge iClk);
        #1;
        check("rst_mid_oValid", {31'b0, oValid}, 32'd0);
        check("rst_mid_oReady", {31'b0, oReady}, 32'd1);
        check("rst_mid_oData", {29'b0, oData}, 32'd0);
        check("rst_mid_oSet", oSet, 32'h0);
        iRst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge iClk);
            #1;
            check("rst_mid_no_result", {31'b0, oValid}, 32'd0);
        end
        runReq("after_rst",   32'h7000_0000, 32'h6FFF_FFFF, 1'b1, 3'b001, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
